// File: rtl/bilinear_ctrl.sv
// Job-queue controller for a bilinear scaler core: queues host jobs, launches them on the core and reports completion.
// Optional performance counters (o_last_cycles, o_jobs_done) are built only when BILINEAR_CTRL_PERF_EN is defined.
module bilinear_ctrl #(
  parameter int QDEPTH = 4
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       i_job_valid,
  output logic                       o_job_ready,
  input  logic [15:0]                i_job_in_w,
  input  logic [15:0]                i_job_in_h,
  input  logic [15:0]                i_job_scale_q88,
  input  logic                       i_err_clr,
  input  logic                       i_step_en,
  input  logic                       i_step_req,
  output logic                       o_core_start,
  output logic [15:0]                o_core_in_w,
  output logic [15:0]                o_core_in_h,
  output logic [15:0]                o_core_scale_q88,
  output logic                       o_core_step_en,
  output logic                       o_core_step_pulse,
  input  logic                       i_core_busy,
  input  logic                       i_core_done,
  output logic                       o_idle,
  output logic                       o_irq,
  output logic                       o_err,
  output logic [$clog2(QDEPTH):0]    o_q_count,
  output logic [15:0]                o_jobs_done,
  output logic [31:0]                o_last_cycles
);

  localparam int AW = $clog2(QDEPTH);
  localparam int CW = AW + 1;

  typedef enum logic [2:0] {S_IDLE, S_LAUNCH, S_WAIT_BUSY, S_RUN, S_COMPLETE} state_t;

  state_t          r_state;
  logic [47:0]     r_mem [QDEPTH];
  logic [AW-1:0]   r_wr_ptr;
  logic [AW-1:0]   r_rd_ptr;
  logic [CW-1:0]   r_count;
  logic            r_err;
  logic            r_irq;
  logic            r_core_start;
  logic [15:0]     r_core_in_w;
  logic [15:0]     r_core_in_h;
  logic [15:0]     r_core_scale;
  logic            r_step_en;
  logic [1:0]      r_req_sync;
  logic            r_req_prev;
  logic            r_step_pulse;

  logic w_full, w_empty, w_legal, w_accept, w_push, w_reject, w_pop, w_launch, w_done_seen;

  assign w_full      = (r_count == CW'(QDEPTH));
  assign w_empty     = (r_count == '0);
  assign w_legal     = (i_job_scale_q88 != 16'd0) && (i_job_in_w >= 16'd2) && (i_job_in_h >= 16'd2);
  assign w_accept    = i_job_valid && !w_full;
  assign w_push      = w_accept && w_legal;
  assign w_reject    = w_accept && !w_legal;
  assign w_pop       = (r_state == S_COMPLETE);
  assign w_launch    = (r_state == S_IDLE) && !w_empty;
  assign w_done_seen = ((r_state == S_WAIT_BUSY) || (r_state == S_RUN)) && i_core_done;

  // NOTE: queue storage has no reset; emptiness is tracked by the pointers and count alone.
  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr_ptr] <= {i_job_in_w, i_job_in_h, i_job_scale_q88};
  end

  // Push and pop may coincide in COMPLETE; the count carries the net change.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
      r_err    <= 1'b0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + AW'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
      r_count <= r_count + CW'(w_push) - CW'(w_pop);
      if (w_reject)       r_err <= 1'b1;
      else if (i_err_clr) r_err <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= S_IDLE;
      r_irq        <= 1'b0;
      r_core_start <= 1'b0;
      r_core_in_w  <= '0;
      r_core_in_h  <= '0;
      r_core_scale <= '0;
    end else begin
      r_irq        <= 1'b0;
      r_core_start <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (w_launch) begin
            {r_core_in_w, r_core_in_h, r_core_scale} <= r_mem[r_rd_ptr];
            r_state <= S_LAUNCH;
          end
        end
        S_LAUNCH: begin
          r_core_start <= 1'b1;
          r_state      <= S_WAIT_BUSY;
        end
        S_WAIT_BUSY: begin
          if (i_core_done) begin
            r_irq   <= 1'b1;
            r_state <= S_COMPLETE;
          end else if (i_core_busy) begin
            r_state <= S_RUN;
          end
        end
        S_RUN: begin
          if (i_core_done) begin
            r_irq   <= 1'b1;
            r_state <= S_COMPLETE;
          end
        end
        S_COMPLETE: r_state <= S_IDLE;
        default:    r_state <= S_IDLE;
      endcase
    end
  end

  // Step requests cross in asynchronously; only synchronized rising edges in RUN become pulses.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_step_en    <= 1'b0;
      r_req_sync   <= '0;
      r_req_prev   <= 1'b0;
      r_step_pulse <= 1'b0;
    end else begin
      r_step_en    <= i_step_en;
      r_req_sync   <= {r_req_sync[0], i_step_req};
      r_req_prev   <= r_req_sync[1];
      r_step_pulse <= r_req_sync[1] && !r_req_prev && (r_state == S_RUN) && r_step_en;
    end
  end

`ifdef BILINEAR_CTRL_PERF_EN
  logic [31:0] r_cyc;
  logic [31:0] r_last_cycles;
  logic [15:0] r_jobs_done;

  // r_cyc holds the inclusive cycle count from LAUNCH up to the current cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cyc         <= '0;
      r_last_cycles <= '0;
      r_jobs_done   <= '0;
    end else begin
      if (w_launch) begin
        r_cyc <= 32'd1;
      end else if (((r_state == S_LAUNCH) || (r_state == S_WAIT_BUSY) || (r_state == S_RUN))
                   && (r_cyc != 32'hFFFF_FFFF)) begin
        r_cyc <= r_cyc + 32'd1;
      end
      if (w_done_seen) begin
        r_last_cycles <= r_cyc;
        r_jobs_done   <= r_jobs_done + 16'd1;
      end
    end
  end

  assign o_last_cycles = r_last_cycles;
  assign o_jobs_done   = r_jobs_done;
`else
  assign o_last_cycles = '0;
  assign o_jobs_done   = '0;
`endif

  assign o_job_ready       = !w_full;
  assign o_idle            = (r_state == S_IDLE) && w_empty;
  assign o_irq             = r_irq;
  assign o_err             = r_err;
  assign o_q_count         = r_count;
  assign o_core_start      = r_core_start;
  assign o_core_in_w       = r_core_in_w;
  assign o_core_in_h       = r_core_in_h;
  assign o_core_scale_q88  = r_core_scale;
  assign o_core_step_en    = r_step_en;
  assign o_core_step_pulse = r_step_pulse;

endmodule

// File: tb/tb_bilinear_ctrl.sv
// Directed testbench for bilinear_ctrl with a small behavioural scaler core that emits one pixel per cycle or per step.
module tb_bilinear_ctrl;

`ifdef BILINEAR_CTRL_PERF_EN
  localparam bit PERF = 1'b1;
`else
  localparam bit PERF = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        i_job_valid = 1'b0;
  logic [15:0] i_job_in_w = '0;
  logic [15:0] i_job_in_h = '0;
  logic [15:0] i_job_scale_q88 = '0;
  logic        i_err_clr = 1'b0;
  logic        i_step_en = 1'b0;
  logic        i_step_req = 1'b0;
  logic        o_job_ready, o_core_start, o_core_step_en, o_core_step_pulse;
  logic [15:0] o_core_in_w, o_core_in_h, o_core_scale_q88, o_jobs_done;
  logic        o_idle, o_irq, o_err;
  logic [2:0]  o_q_count;
  logic [31:0] o_last_cycles;
  logic        c_busy, c_done;
  int          c_pix, c_total;

  int n_cmp = 0;
  int n_bad = 0;
  int irq_cnt = 0;
  int start_cnt = 0;
  int step_cnt = 0;
  logic [47:0] launched[$];

  always #5 clk = ~clk;

  bilinear_ctrl #(.QDEPTH(4)) dut (
    .clk(clk), .rst_n(rst_n),
    .i_job_valid(i_job_valid), .o_job_ready(o_job_ready),
    .i_job_in_w(i_job_in_w), .i_job_in_h(i_job_in_h), .i_job_scale_q88(i_job_scale_q88),
    .i_err_clr(i_err_clr), .i_step_en(i_step_en), .i_step_req(i_step_req),
    .o_core_start(o_core_start), .o_core_in_w(o_core_in_w), .o_core_in_h(o_core_in_h),
    .o_core_scale_q88(o_core_scale_q88), .o_core_step_en(o_core_step_en),
    .o_core_step_pulse(o_core_step_pulse), .i_core_busy(c_busy), .i_core_done(c_done),
    .o_idle(o_idle), .o_irq(o_irq), .o_err(o_err), .o_q_count(o_q_count),
    .o_jobs_done(o_jobs_done), .o_last_cycles(o_last_cycles)
  );

  function automatic int out_pixels(input int w, input int h, input int s);
    return ((w * s) >> 8) * ((h * s) >> 8);
  endfunction

  // Behavioural core: one output pixel per cycle, or per step pulse when stepping is enabled.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      c_busy <= 1'b0; c_done <= 1'b0; c_pix <= 0; c_total <= 0;
    end else begin
      c_done <= 1'b0;
      if (o_core_start && !c_busy) begin
        c_busy  <= 1'b1;
        c_pix   <= 0;
        c_total <= out_pixels(int'(o_core_in_w), int'(o_core_in_h), int'(o_core_scale_q88));
      end else if (c_busy && (!o_core_step_en || o_core_step_pulse)) begin
        c_pix <= c_pix + 1;
        if (c_pix + 1 == c_total) begin
          c_busy <= 1'b0;
          c_done <= 1'b1;
        end
      end
    end
  end

  always @(negedge clk) begin
    if (o_irq) irq_cnt++;
    if (o_core_step_pulse) step_cnt++;
    if (o_core_start) begin
      start_cnt++;
      launched.push_back({o_core_in_w, o_core_in_h, o_core_scale_q88});
    end
  end

  task automatic check(input string tag, input logic [47:0] got, input logic [47:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic push_job(input logic [15:0] w, input logic [15:0] h, input logic [15:0] s,
                          output int waited);
    i_job_valid = 1'b1; i_job_in_w = w; i_job_in_h = h; i_job_scale_q88 = s;
    waited = 0;
    while (!o_job_ready && waited < 500) begin tick(); waited++; end
    check("push_ready", o_job_ready, 1'b1);
    tick();
  endtask

  // Scrambled data after the handshake must not leak into queued or running jobs.
  task automatic end_push();
    i_job_valid = 1'b0; i_job_in_w = 16'hDEAD; i_job_in_h = 16'hBEEF; i_job_scale_q88 = 16'h0000;
  endtask

  task automatic wait_irq(input int target, input string tag);
    int n = 0;
    while (irq_cnt < target && n < 3000) begin tick(); n++; end
    check(tag, irq_cnt, target);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_start"}, o_core_start, 1'b0);
    check({tag, "_params"}, {o_core_in_w, o_core_in_h, o_core_scale_q88}, 48'h0);
    check({tag, "_flags"}, {o_irq, o_err, o_core_step_en, o_core_step_pulse}, 4'b0000);
    check({tag, "_qcount"}, o_q_count, 3'd0);
    check({tag, "_ready_idle"}, {o_job_ready, o_idle}, 2'b11);
    check({tag, "_perf"}, {o_jobs_done, o_last_cycles}, 48'h0);
  endtask

  initial begin
    int w, base_irq, base_start, base_step;
    logic [47:0] exp_jobs [5];

    repeat (3) tick();
    check_reset_outputs("reset");
    rst_n = 1'b1;
    tick();

    // Single 4x4 job at 2x: 64 pixels, latency LAUNCH..done = 64 + 3 cycles.
    push_job(16'd4, 16'd4, 16'h0200, w);
    end_push();
    wait_irq(1, "single_irq");
    tick();
    check("single_starts", start_cnt, 1);
    check("single_params", launched[0], {16'd4, 16'd4, 16'h0200});
    check("single_pixels", c_pix, 64);
    check("single_jobs_done", o_jobs_done, PERF ? 16'd1 : 16'd0);
    check("single_last_cycles", o_last_cycles, PERF ? 32'd67 : 32'd0);
    check("single_idle", o_idle, 1'b1);

    // Illegal jobs are dropped; an error set coinciding with a clear keeps the error.
    base_start = start_cnt;
    push_job(16'd5, 16'd5, 16'h0000, w);
    push_job(16'd1, 16'd4, 16'h0100, w);
    end_push();
    check("illegal_qcount", o_q_count, 3'd0);
    check("illegal_err", o_err, 1'b1);
    i_err_clr = 1'b1; tick(); i_err_clr = 1'b0;
    check("err_clr", o_err, 1'b0);
    i_err_clr = 1'b1;
    push_job(16'd4, 16'd1, 16'h0100, w);
    i_err_clr = 1'b0;
    end_push();
    check("err_set_wins", o_err, 1'b1);
    i_err_clr = 1'b1; tick(); i_err_clr = 1'b0;
    check("err_clr2", o_err, 1'b0);
    repeat (3) tick();
    check("illegal_no_start", start_cnt, base_start);

    // Queue full: fifth job waits until the first COMPLETE has popped.
    exp_jobs[0] = {16'd2, 16'd2, 16'h0100};
    exp_jobs[1] = {16'd3, 16'd2, 16'h0100};
    exp_jobs[2] = {16'd2, 16'd3, 16'h0100};
    exp_jobs[3] = {16'd4, 16'd2, 16'h0100};
    exp_jobs[4] = {16'd2, 16'd4, 16'h0100};
    base_irq = irq_cnt; base_start = start_cnt;
    for (int i = 0; i < 4; i++) push_job(exp_jobs[i][47:32], exp_jobs[i][31:16], exp_jobs[i][15:0], w);
    check("full_qcount", o_q_count, 3'd4);
    check("full_ready", o_job_ready, 1'b0);
    push_job(exp_jobs[4][47:32], exp_jobs[4][31:16], exp_jobs[4][15:0], w);
    end_push();
    check("full_waited", (w > 0), 1'b1);
    check("full_irq_at_accept", irq_cnt, base_irq + 1);
    wait_irq(base_irq + 5, "full_irqs");
    for (int i = 0; i < 5; i++) check($sformatf("full_order%0d", i), launched[base_start + i], exp_jobs[i]);
    check("full_jobs_done", o_jobs_done, PERF ? 16'd6 : 16'd0);

    // Stepping: core stalls per pixel, four step edges complete a 2x2 job; later edges are discarded.
    i_step_en = 1'b1;
    tick(); tick();
    check("step_en_reg", o_core_step_en, 1'b1);
    base_irq = irq_cnt; base_step = step_cnt;
    push_job(16'd2, 16'd2, 16'h0100, w);
    end_push();
    w = 0;
    while (!c_busy && w < 50) begin tick(); w++; end
    check("step_core_busy", c_busy, 1'b1);
    repeat (4) tick();
    check("step_stalled", c_pix, 0);
    for (int i = 0; i < 4; i++) begin
      i_step_req = 1'b1; repeat (4) tick();
      i_step_req = 1'b0; repeat (4) tick();
    end
    check("step_pulses", step_cnt, base_step + 4);
    wait_irq(base_irq + 1, "step_irq");
    check("step_pixels", c_pix, 4);
    i_step_req = 1'b1; repeat (4) tick();
    i_step_req = 1'b0; repeat (4) tick();
    check("step_discard", step_cnt, base_step + 4);
    i_step_en = 1'b0;
    tick(); tick();

    // Push during COMPLETE with one job in the queue: count stays 1 and the new job launches next.
    base_start = start_cnt;
    push_job(16'd2, 16'd2, 16'h0100, w);
    end_push();
    w = 0;
    while (!o_irq && w < 200) begin tick(); w++; end
    check("cpush_in_complete", o_irq, 1'b1);
    check("cpush_qcount_before", o_q_count, 3'd1);
    push_job(16'd3, 16'd3, 16'h0100, w);
    end_push();
    check("cpush_qcount_after", o_q_count, 3'd1);
    w = 0;
    while (start_cnt < base_start + 2 && w < 50) begin tick(); w++; end
    check("cpush_next_launch", launched[base_start + 1], {16'd3, 16'd3, 16'h0100});
    wait_irq(irq_cnt + 1, "cpush_irq");
    check("cpush_jobs_done", o_jobs_done, PERF ? 16'd9 : 16'd0);

    // Reset during pixel 10 of an 8x8 output abandons the job without an interrupt.
    push_job(16'd4, 16'd4, 16'h0200, w);
    end_push();
    w = 0;
    while (c_pix != 10 && w < 200) begin tick(); w++; end
    check("rst_at_pixel10", c_pix, 10);
    base_irq = irq_cnt;
    rst_n = 1'b0;
    #1;
    check_reset_outputs("midrun_reset");
    tick(); tick();
    rst_n = 1'b1;
    repeat (5) tick();
    check("midrun_no_irq", irq_cnt, base_irq);
    base_start = start_cnt;
    push_job(16'd2, 16'd2, 16'h0100, w);
    end_push();
    wait_irq(base_irq + 1, "post_reset_irq");
    tick();
    check("post_reset_params", launched[base_start], {16'd2, 16'd2, 16'h0100});
    check("post_reset_jobs_done", o_jobs_done, PERF ? 16'd1 : 16'd0);
    check("post_reset_last_cycles", o_last_cycles, PERF ? 32'd7 : 32'd0);
    check("post_reset_idle", o_idle, 1'b1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
